// File: rtl/hs32_regctl.sv
// hs32_regctl: operand-fetch controller sitting between decode, a 2-read/1-write register
// file and execute.
//
// A read request latches two source addresses, spends one FETCH cycle letting the register
// file drive the read data (it updates rf_dout* on negedge), then captures both operands
// and holds them until execute takes them. Writebacks pass straight through to the
// register file whenever wb_ready is high.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   rd_valid/rd_ready, rd_a1/2  operand-read request from decode
//   op_valid/op_ready, op_d1/2  captured operand pair to execute
//   wb_valid/wb_ready, wb_adr,
//   wb_data                     writeback request
//   rf_we, rf_wadr, rf_din      register-file write port
//   rf_radr1/2, rf_dout1/2      register-file read ports
//
// Build option: define HS32_REGCTL_WBPRIO_EN to let writebacks proceed during FETCH; an
// accepted write then stalls the capture for one more FETCH cycle.
module hs32_regctl (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_valid,
  output logic        rd_ready,
  input  logic [3:0]  rd_a1,
  input  logic [3:0]  rd_a2,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_d1,
  output logic [31:0] op_d2,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [3:0]  wb_adr,
  input  logic [31:0] wb_data,
  output logic        rf_we,
  output logic [3:0]  rf_wadr,
  output logic [31:0] rf_din,
  output logic [3:0]  rf_radr1,
  output logic [3:0]  rf_radr2,
  input  logic [31:0] rf_dout1,
  input  logic [31:0] rf_dout2
);

  typedef enum logic [1:0] {StIdle, StFetch, StValid} state_e;

  state_e      state_q;
  logic [3:0]  a1_q, a2_q;
  logic [31:0] op_d1_q, op_d2_q;
  logic        op_valid_q;
  logic        rd_fire, wb_fire;

  always_comb begin
    rd_ready = 1'b0;
    wb_ready = 1'b1;
    case (state_q)
      StIdle:  rd_ready = 1'b1;
      StFetch: begin
        rd_ready = 1'b0;
`ifdef HS32_REGCTL_WBPRIO_EN
        wb_ready = 1'b1;
`else
        // The register file only refreshes read data on a negedge without a write.
        wb_ready = 1'b0;
`endif
      end
      StValid: rd_ready = op_ready;
      default: begin
        rd_ready = 1'b0;
        wb_ready = 1'b0;
      end
    endcase
  end

  assign rd_fire  = rd_valid & rd_ready;
  assign wb_fire  = wb_valid & wb_ready;

  assign rf_we    = wb_fire;
  assign rf_wadr  = wb_adr;
  assign rf_din   = wb_data;
  assign rf_radr1 = a1_q;
  assign rf_radr2 = a2_q;

  assign op_valid = op_valid_q;
  assign op_d1    = op_d1_q;
  assign op_d2    = op_d2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      a1_q       <= 4'd0;
      a2_q       <= 4'd0;
      op_d1_q    <= 32'd0;
      op_d2_q    <= 32'd0;
      op_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (rd_fire) begin
            a1_q    <= rd_a1;
            a2_q    <= rd_a2;
            state_q <= StFetch;
          end
        end
        StFetch: begin
          // A write in this cycle blocked the negedge read refresh, so the data is stale.
          if (!wb_fire) begin
            op_d1_q    <= rf_dout1;
            op_d2_q    <= rf_dout2;
            op_valid_q <= 1'b1;
            state_q    <= StValid;
          end
        end
        StValid: begin
          if (op_ready) begin
            op_valid_q <= 1'b0;
            if (rd_fire) begin
              a1_q    <= rd_a1;
              a2_q    <= rd_a2;
              state_q <= StFetch;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: begin
          op_valid_q <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hs32_regctl.sv
// Bench for hs32_regctl: a register-file model on the rf_* ports, directed stimulus that
// pushes hand-computed operand pairs into a queue, and a monitor that pops and compares on
// every op_valid && op_ready transfer.
module tb_hs32_regctl;

`ifdef HS32_REGCTL_WBPRIO_EN
  localparam logic WbPrio = 1'b1;
`else
  localparam logic WbPrio = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_valid, rd_ready;
  logic [3:0]  rd_a1, rd_a2;
  logic        op_valid, op_ready;
  logic [31:0] op_d1, op_d2;
  logic        wb_valid, wb_ready;
  logic [3:0]  wb_adr;
  logic [31:0] wb_data;
  logic        rf_we;
  logic [3:0]  rf_wadr, rf_radr1, rf_radr2;
  logic [31:0] rf_din;
  logic [31:0] rf_dout1 = 32'd0;
  logic [31:0] rf_dout2 = 32'd0;
  logic [31:0] regs [16] = '{default: 32'd0};

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  hs32_regctl u_dut (
    .clk      (clk),
    .reset    (reset),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_a1    (rd_a1),
    .rd_a2    (rd_a2),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_d1    (op_d1),
    .op_d2    (op_d2),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_adr   (wb_adr),
    .wb_data  (wb_data),
    .rf_we    (rf_we),
    .rf_wadr  (rf_wadr),
    .rf_din   (rf_din),
    .rf_radr1 (rf_radr1),
    .rf_radr2 (rf_radr2),
    .rf_dout1 (rf_dout1),
    .rf_dout2 (rf_dout2)
  );

  // Register file: writes on negedge, otherwise refreshes read data on negedge.
  always @(negedge clk) begin
    if (rf_we) begin
      regs[rf_wadr] <= rf_din;
    end else begin
      rf_dout1 <= regs[rf_radr1];
      rf_dout2 <= regs[rf_radr2];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Monitor: a transfer completes at the posedge following a negedge with valid && ready.
  always @(negedge clk) begin
    if (reset === 1'b1 && op_valid === 1'b1 && op_ready === 1'b1) begin
      logic [63:0] e;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_op: got %08h/%08h, expected no transfer", op_d1, op_d2);
      end else begin
        e = exp_q.pop_front();
        check("op_d1", op_d1, e[63:32]);
        check("op_d2", op_d2, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout, expected handshake within 20 cycles", name);
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] data);
    int n = 0;
    wb_valid = 1'b1; wb_adr = adr; wb_data = data;
    #1;
    while (!wb_ready && n < 20) begin tick(); n++; end
    if (!wb_ready) timeout("wr_wait");
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a1, input logic [3:0] a2);
    int n = 0;
    rd_valid = 1'b1; rd_a1 = a1; rd_a2 = a2;
    #1;
    while (!rd_ready && n < 20) begin tick(); n++; end
    if (!rd_ready) timeout("rd_wait");
    tick();
    rd_valid = 1'b0;
  endtask

  // Idle is the only state with rd_ready=1 and op_valid=0.
  task automatic wait_idle();
    int n = 0;
    while (!(rd_ready && !op_valid) && n < 20) begin tick(); n++; end
    if (!(rd_ready && !op_valid)) timeout("wait_idle");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; rd_valid = 1'b0; rd_a1 = 4'd0; rd_a2 = 4'd0; op_ready = 1'b1;
    wb_valid = 1'b1; wb_adr = 4'd9; wb_data = 32'h0BAD_F00D;

    // Reset state, write passthrough during reset.
    repeat (2) tick();
    check("rst_op_valid", {31'd0, op_valid}, 32'd0);
    check("rst_op_d1", op_d1, 32'd0);
    check("rst_rd_ready", {31'd0, rd_ready}, 32'd1);
    check("rst_wb_ready", {31'd0, wb_ready}, 32'd1);
    check("rst_radr1", {28'd0, rf_radr1}, 32'd0);
    check("rst_rf_we", {31'd0, rf_we}, 32'd1);
    check("rst_rf_wadr", {28'd0, rf_wadr}, 32'd9);
    check("rst_rf_din", rf_din, 32'h0BAD_F00D);
    wb_valid = 1'b0;
    #1;
    check("rst_rf_we_low", {31'd0, rf_we}, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Write R3 in idle, then read it: op_valid in the second cycle after accept.
    wr(4'd3, 32'hDEAD_BEEF);
    exp_q.push_back({32'hDEAD_BEEF, 32'd0});
    rd(4'd3, 4'd0);
    check("lat_fetch_opv", {31'd0, op_valid}, 32'd0);
    check("fetch_rd_ready", {31'd0, rd_ready}, 32'd0);
    check("fetch_wb_ready", {31'd0, wb_ready}, {31'd0, WbPrio});
    check("fetch_radr1", {28'd0, rf_radr1}, 32'd3);
    tick();
    check("lat_valid_opv", {31'd0, op_valid}, 32'd1);
    wait_idle();

    // Write-before-read on simultaneous accept.
    exp_q.push_back({32'h1234_5678, 32'h1234_5678});
    rd_valid = 1'b1; rd_a1 = 4'd5; rd_a2 = 4'd5;
    wb_valid = 1'b1; wb_adr = 4'd5; wb_data = 32'h1234_5678;
    #1;
    check("simul_rd_ready", {31'd0, rd_ready}, 32'd1);
    check("simul_wb_ready", {31'd0, wb_ready}, 32'd1);
    tick();
    rd_valid = 1'b0; wb_valid = 1'b0;
    wait_idle();

    // Writeback held during a FETCH cycle.
    exp_q.push_back({(WbPrio ? 32'hCAFE_F00D : 32'd0), 32'd0});
    rd(4'd6, 4'd0);
    wb_valid = 1'b1; wb_adr = 4'd6; wb_data = 32'hCAFE_F00D;
    #1;
    check("wbprio_wb_ready", {31'd0, wb_ready}, {31'd0, WbPrio});
    check("wbprio_rf_we", {31'd0, rf_we}, {31'd0, WbPrio});
    tick();
    wb_valid = 1'b0;
    #1;
    check("wbprio_opv", {31'd0, op_valid}, {31'd0, !WbPrio});
    wait_idle();

    // Execute stalls with op_d held; a write to R1 in VALID must not disturb it.
    wr(4'd1, 32'h0000_0001);
    op_ready = 1'b0;
    exp_q.push_back({32'h0000_0001, 32'h0000_0001});
    rd(4'd1, 4'd1);
    tick();
    rd_valid = 1'b1; rd_a1 = 4'd7; rd_a2 = 4'd7;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        wb_valid = 1'b1; wb_adr = 4'd1; wb_data = 32'hA5A5_A5A5;
        #1;
        check("stall_wb_ready", {31'd0, wb_ready}, 32'd1);
      end
      check("stall_opv", {31'd0, op_valid}, 32'd1);
      check("stall_op_d1", op_d1, 32'h0000_0001);
      check("stall_rd_ready", {31'd0, rd_ready}, 32'd0);
      tick();
      wb_valid = 1'b0;
    end
    check("stall_op_d1_after_wb", op_d1, 32'h0000_0001);
    check("stall_r1_written", regs[1], 32'hA5A5_A5A5);
    rd_valid = 1'b0;
    op_ready = 1'b1;
    #1;
    check("unstall_rd_ready", {31'd0, rd_ready}, 32'd1);
    wait_idle();

    // Back-to-back reads, one pair every 2 cycles.
    wr(4'd2, 32'h2222_2222);
    wr(4'd4, 32'h4444_4444);
    exp_q.push_back({32'h2222_2222, 32'h2222_2222});
    exp_q.push_back({32'h4444_4444, 32'h4444_4444});
    rd_valid = 1'b1; rd_a1 = 4'd2; rd_a2 = 4'd2;
    #1;
    check("b2b_acc0", {31'd0, rd_ready}, 32'd1);
    tick();
    rd_a1 = 4'd4; rd_a2 = 4'd4;
    check("b2b_fetch0_opv", {31'd0, op_valid}, 32'd0);
    check("b2b_fetch0_rdy", {31'd0, rd_ready}, 32'd0);
    tick();
    check("b2b_valid0_opv", {31'd0, op_valid}, 32'd1);
    check("b2b_valid0_rdy", {31'd0, rd_ready}, 32'd1);
    tick();
    rd_valid = 1'b0;
    check("b2b_fetch1_opv", {31'd0, op_valid}, 32'd0);
    check("b2b_fetch1_radr", {28'd0, rf_radr1}, 32'd4);
    tick();
    check("b2b_valid1_opv", {31'd0, op_valid}, 32'd1);
    wait_idle();

    // Reset mid-FETCH drops the pending pair asynchronously.
    rd_valid = 1'b1; rd_a1 = 4'd3; rd_a2 = 4'd3;
    #1;
    tick();
    rd_valid = 1'b0;
    check("pre_rst_op_d1", op_d1, 32'h4444_4444);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_opv", {31'd0, op_valid}, 32'd0);
    check("mid_rst_op_d1", op_d1, 32'd0);
    check("mid_rst_op_d2", op_d2, 32'd0);
    check("mid_rst_radr1", {28'd0, rf_radr1}, 32'd0);
    check("mid_rst_rd_ready", {31'd0, rd_ready}, 32'd1);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("post_rst_idle", {31'd0, rd_ready}, 32'd1);
    exp_q.push_back({32'hDEAD_BEEF, 32'h4444_4444});
    rd(4'd3, 4'd4);
    tick();
    check("post_rst_opv", {31'd0, op_valid}, 32'd1);
    wait_idle();

    repeat (2) tick();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
